// File: rtl/niosII_system_sysid_pkg.sv
// Shared definitions for the system-ID checker: FSM state encoding,
// system-ID slave word offsets and default expected values.
package niosII_system_sysid_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ_ID,
      S_WAIT_ID,
      S_REQ_TS,
      S_WAIT_TS,
      S_CHECK,
      S_FINISH
   } sysid_state_t;

   localparam int unsigned SYSID_ID_OFFSET = 0;
   localparam int unsigned SYSID_TS_OFFSET = 1;

   localparam logic [31:0] DEFAULT_EXPECTED_ID    = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_EXPECTED_TS    = 32'h58D8_4C26;
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/niosII_system_sysid_timeout.sv
// Loadable down-counter used as the per-transaction read timeout.
// Ports:
//   clock, reset_n : clock and async active-low reset
//   load           : reload the counter with LOAD_VALUE (wins over count_en)
//   count_en       : decrement by one, saturating at zero
//   expired        : counter is at zero
module niosII_system_sysid_timeout #(
   parameter int unsigned LOAD_VALUE = 1023
) (
   input  logic clock,
   input  logic reset_n,
   input  logic load,
   input  logic count_en,
   output logic expired
);

   logic [15:0] count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= 16'(LOAD_VALUE);
      end else if (count_en && (count != '0)) begin
         count <= count - 16'd1;
      end
   end

   assign expired = (count == '0);

endmodule

// File: rtl/niosii_system_sysid_checker.sv
// Avalon-MM read master that reads the system-ID slave (word 0 = ID,
// word 1 = build timestamp) after start, compares both against expected
// values and reports pass/fail/timeout. All outputs are registered.
// Ports:
//   clock, reset_n           : clock and async active-low reset
//   start                    : one-cycle check request, ignored while busy
//   avm_address, avm_read    : registered read command
//   avm_waitrequest          : slave stall
//   avm_readdatavalid/-data  : read response
//   busy, done               : check in progress / sticky result valid
//   id_ok, ts_ok             : captured words equal the expected values
//   timeout_err              : a read exceeded TIMEOUT_CYCLES
//   id_value, ts_value       : captured words
//
// state     | meaning
// ----------+------------------------------------------------
// S_IDLE    | waiting for start, results held
// S_REQ_ID  | read command to word 0 on the bus
// S_WAIT_ID | word 0 accepted, waiting for readdatavalid
// S_REQ_TS  | read command to word 1 on the bus
// S_WAIT_TS | word 1 accepted, waiting for readdatavalid
// S_CHECK   | register the comparisons
// S_FINISH  | raise done, drop busy
module niosii_system_sysid_checker
   import niosII_system_sysid_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
   parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter int unsigned ADDR_W         = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic              avm_readdatavalid,
   input  logic [31:0]       avm_readdata,
   output logic              busy,
   output logic              done,
   output logic              id_ok,
   output logic              ts_ok,
   output logic              timeout_err,
   output logic [31:0]       id_value,
   output logic [31:0]       ts_value
);

   sysid_state_t state, next_state;

   logic accept;
   logic start_accept;
   logic load_tmr;
   logic count_en;
   logic expired;
   logic capture_id;
   logic capture_ts;
   logic tmo;

   niosII_system_sysid_timeout #(
      .LOAD_VALUE (TIMEOUT_CYCLES - 1)
   ) u_timeout (
      .clock    (clock),
      .reset_n  (reset_n),
      .load     (load_tmr),
      .count_en (count_en),
      .expired  (expired)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= next_state;
   end

   // Completion takes priority over the timeout so a read finishing on the
   // last allowed cycle still counts; an accept without data at that point
   // is not a completion and times out.
   always_comb begin
      next_state   = state;
      start_accept = 1'b0;
      load_tmr     = 1'b0;
      capture_id   = 1'b0;
      capture_ts   = 1'b0;
      tmo          = 1'b0;
      accept       = avm_read && !avm_waitrequest;
      count_en     = (state == S_REQ_ID) || (state == S_WAIT_ID) ||
                     (state == S_REQ_TS) || (state == S_WAIT_TS);
      case (state)
         S_IDLE: begin
            if (start) begin
               start_accept = 1'b1;
               load_tmr     = 1'b1;
               next_state   = S_REQ_ID;
            end
         end
         S_REQ_ID: begin
            if (accept && avm_readdatavalid) begin
               capture_id = 1'b1;
               load_tmr   = 1'b1;
               next_state = S_REQ_TS;
            end else if (expired) begin
               tmo        = 1'b1;
               next_state = S_FINISH;
            end else if (accept) begin
               next_state = S_WAIT_ID;
            end
         end
         S_WAIT_ID: begin
            if (avm_readdatavalid) begin
               capture_id = 1'b1;
               load_tmr   = 1'b1;
               next_state = S_REQ_TS;
            end else if (expired) begin
               tmo        = 1'b1;
               next_state = S_FINISH;
            end
         end
         S_REQ_TS: begin
            if (accept && avm_readdatavalid) begin
               capture_ts = 1'b1;
               next_state = S_CHECK;
            end else if (expired) begin
               tmo        = 1'b1;
               next_state = S_FINISH;
            end else if (accept) begin
               next_state = S_WAIT_TS;
            end
         end
         S_WAIT_TS: begin
            if (avm_readdatavalid) begin
               capture_ts = 1'b1;
               next_state = S_CHECK;
            end else if (expired) begin
               tmo        = 1'b1;
               next_state = S_FINISH;
            end
         end
         S_CHECK:  next_state = S_FINISH;
         S_FINISH: next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Bus command is derived from next_state so it is registered yet lines
   // up with the state that owns it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         avm_read    <= 1'b0;
         avm_address <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         id_ok       <= 1'b0;
         ts_ok       <= 1'b0;
         timeout_err <= 1'b0;
         id_value    <= '0;
         ts_value    <= '0;
      end else begin
         avm_read    <= (next_state == S_REQ_ID) || (next_state == S_REQ_TS);
         avm_address <= ((next_state == S_REQ_TS) || (next_state == S_WAIT_TS)) ?
                        ADDR_W'(SYSID_TS_OFFSET) : ADDR_W'(SYSID_ID_OFFSET);
         if (start_accept) begin
            busy        <= 1'b1;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout_err <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
         end
         if (capture_id) id_value <= avm_readdata;
         if (capture_ts) ts_value <= avm_readdata;
         if (tmo) begin
            timeout_err <= 1'b1;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
         end
         if (state == S_CHECK) begin
            id_ok <= (id_value == EXPECTED_ID);
            ts_ok <= (ts_value == EXPECTED_TS);
         end
         if (state == S_FINISH) begin
            done <= 1'b1;
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_niosii_system_sysid_checker.sv
// Directed bench for the system-ID checker with a behavioural system-ID
// slave (programmable wait states, read latency and a hang on word 1).
// Cycle n is the n-th cycle after the one in which start is sampled.
module tb_niosii_system_sysid_checker;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic [0:0]  avm_address;
   logic        avm_read;
   logic        avm_waitrequest = 1'b0;
   logic        avm_readdatavalid = 1'b0;
   logic [31:0] avm_readdata = 32'hDEAD_BEEF;
   logic        busy, done, id_ok, ts_ok, timeout_err;
   logic [31:0] id_value, ts_value;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem0, mem1;
   int          cfg_ws, cfg_lat;
   bit          hang_ts;

   always #5 clock = ~clock;

   niosii_system_sysid_checker #(
      .EXPECTED_ID    (32'h0000_0000),
      .EXPECTED_TS    (32'h58D8_4C26),
      .TIMEOUT_CYCLES (8),
      .ADDR_W         (1)
   ) dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .start             (start),
      .avm_address       (avm_address),
      .avm_read          (avm_read),
      .avm_waitrequest   (avm_waitrequest),
      .avm_readdatavalid (avm_readdatavalid),
      .avm_readdata      (avm_readdata),
      .busy              (busy),
      .done              (done),
      .id_ok             (id_ok),
      .ts_ok             (ts_ok),
      .timeout_err       (timeout_err),
      .id_value          (id_value),
      .ts_value          (ts_value)
   );

   // Slave: responds just after each rising edge to the freshly registered command.
   initial begin : slave
      bit         pend;
      int         lat_cnt;
      int         ws_cnt;
      logic [0:0] paddr;
      pend = 0; lat_cnt = 0; ws_cnt = 0; paddr = '0;
      forever begin
         @(posedge clock); #1;
         avm_waitrequest   = 1'b0;
         avm_readdatavalid = 1'b0;
         avm_readdata      = 32'hDEAD_BEEF;
         if (!reset_n) begin
            pend = 0; ws_cnt = 0;
         end else begin
            if (pend) begin
               lat_cnt--;
               if (lat_cnt == 0) begin
                  avm_readdatavalid = 1'b1;
                  avm_readdata      = paddr[0] ? mem1 : mem0;
                  pend = 0;
               end
            end
            if (avm_read) begin
               if (hang_ts && avm_address[0]) begin
                  avm_waitrequest = 1'b1;
               end else if (ws_cnt < cfg_ws) begin
                  avm_waitrequest = 1'b1;
                  ws_cnt++;
               end else begin
                  ws_cnt = 0;
                  if (cfg_lat == 0) begin
                     avm_readdatavalid = 1'b1;
                     avm_readdata      = avm_address[0] ? mem1 : mem0;
                  end else begin
                     pend    = 1;
                     lat_cnt = cfg_lat;
                     paddr   = avm_address;
                  end
               end
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Pulses start, then watches up to 60 cycles for done. Optionally pulses
   // start again at cycle extra_start. Records accepted reads, the last cycle
   // avm_read was high and whether the command stayed put during stalls.
   task automatic run_check(input int extra_start, output int done_cyc, output int reads,
                            output int last_read, output bit stall_ok);
      bit         prev_stall;
      logic [0:0] prev_addr;
      done_cyc = -1; reads = 0; last_read = 0; stall_ok = 1;
      prev_stall = 0; prev_addr = '0;
      @(negedge clock);
      start = 1'b1;
      for (int n = 1; n <= 60 && done_cyc < 0; n++) begin
         @(negedge clock);
         start = (n == extra_start);
         if (avm_read) last_read = n;
         if (avm_read && !avm_waitrequest) reads++;
         if (avm_read && avm_waitrequest) begin
            if (prev_stall && (avm_address != prev_addr)) stall_ok = 0;
            prev_stall = 1;
            prev_addr  = avm_address;
         end else begin
            if (prev_stall && !avm_read && !timeout_err) stall_ok = 0;
            prev_stall = 0;
         end
         if (done) done_cyc = n;
      end
      start = 1'b0;
   endtask

   initial begin : stim
      int done_cyc, reads, last_read;
      bit stall_ok;

      mem0 = 32'h0000_0000; mem1 = 32'h58D8_4C26;
      cfg_ws = 0; cfg_lat = 0; hang_ts = 0;

      // Reset values
      repeat (3) @(negedge clock);
      check("rst_avm_read", 32'(avm_read), 32'd0);
      check("rst_avm_address", 32'(avm_address), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_oks", 32'({id_ok, ts_ok, timeout_err}), 32'd0);
      check("rst_id_value", id_value, 32'd0);
      check("rst_ts_value", ts_value, 32'd0);
      reset_n = 1'b1;
      @(negedge clock);

      // Matching zero-latency slave: done at cycle 5
      run_check(0, done_cyc, reads, last_read, stall_ok);
      check("match_done_cyc", 32'(done_cyc), 32'd5);
      check("match_id_ok", 32'(id_ok), 32'd1);
      check("match_ts_ok", 32'(ts_ok), 32'd1);
      check("match_timeout", 32'(timeout_err), 32'd0);
      check("match_busy", 32'(busy), 32'd0);
      check("match_reads", 32'(reads), 32'd2);
      check("match_ts_value", ts_value, 32'h58D8_4C26);

      // Mismatched timestamp
      mem1 = 32'h58D8_4C27;
      run_check(0, done_cyc, reads, last_read, stall_ok);
      check("mism_id_ok", 32'(id_ok), 32'd1);
      check("mism_ts_ok", 32'(ts_ok), 32'd0);
      check("mism_ts_value", ts_value, 32'h58D8_4C27);
      check("mism_done_cyc", 32'(done_cyc), 32'd5);

      // Backpressure (3 wait states) and 2-cycle latency: done at 5+2*(3+2)
      mem1 = 32'h58D8_4C26; cfg_ws = 3; cfg_lat = 2;
      run_check(0, done_cyc, reads, last_read, stall_ok);
      check("bp_done_cyc", 32'(done_cyc), 32'd15);
      check("bp_stall_stable", 32'(stall_ok), 32'd1);
      check("bp_reads", 32'(reads), 32'd2);
      check("bp_id_value", id_value, 32'h0000_0000);
      check("bp_ts_value", ts_value, 32'h58D8_4C26);
      check("bp_oks", 32'({id_ok, ts_ok, timeout_err}), 32'b110);

      // Boundary: 7 wait states, accept on the 8th (last allowed) cycle
      cfg_ws = 7; cfg_lat = 0;
      run_check(0, done_cyc, reads, last_read, stall_ok);
      check("edge_done_cyc", 32'(done_cyc), 32'd19);
      check("edge_timeout", 32'(timeout_err), 32'd0);
      check("edge_oks", 32'({id_ok, ts_ok}), 32'b11);

      // Timeout on word 1: read high cycles 1..9, done at cycle 11
      cfg_ws = 0; hang_ts = 1; mem0 = 32'h1234_5678;
      run_check(0, done_cyc, reads, last_read, stall_ok);
      check("tmo_last_read", 32'(last_read), 32'd9);
      check("tmo_done_cyc", 32'(done_cyc), 32'd11);
      check("tmo_timeout", 32'(timeout_err), 32'd1);
      check("tmo_oks", 32'({id_ok, ts_ok}), 32'b00);
      check("tmo_id_value", id_value, 32'h1234_5678);
      check("tmo_stall_stable", 32'(stall_ok), 32'd1);

      // start while busy is ignored
      hang_ts = 0; mem0 = 32'h0000_0000;
      run_check(2, done_cyc, reads, last_read, stall_ok);
      check("busy_reads", 32'(reads), 32'd2);
      check("busy_done_cyc", 32'(done_cyc), 32'd5);
      check("busy_timeout_clr", 32'(timeout_err), 32'd0);
      repeat (4) @(negedge clock);
      check("busy_no_rerun", 32'({busy, avm_read}), 32'b00);

      // Reset during WAIT_ID
      cfg_lat = 5;
      @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(negedge clock);
      check("midrst_in_wait", 32'({busy, avm_read}), 32'b10);
      reset_n = 1'b0;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_read_addr", 32'({avm_read, avm_address}), 32'd0);
      check("midrst_flags", 32'({done, id_ok, ts_ok, timeout_err}), 32'd0);
      check("midrst_values", id_value | ts_value, 32'd0);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      cfg_lat = 0;
      @(negedge clock);

      // Fresh run after reset
      run_check(0, done_cyc, reads, last_read, stall_ok);
      check("post_done_cyc", 32'(done_cyc), 32'd5);
      check("post_oks", 32'({id_ok, ts_ok, timeout_err}), 32'b110);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/niosii_system_sysid_checker.md
# niosII_system_sysid_checker

Avalon-MM read master that interrogates the system-ID slave (word 0 = system ID, word 1 = build timestamp) after `start`. It compares both words against build-time expected values and reports pass/fail/timeout to the board-level health logic. It sits beside the Nios II on the same Avalon fabric and lets hardware refuse to run a mismatched software image.

## Interface
Parameters:
- `EXPECTED_ID`, 32'h0000_0000, expected value at word 0
- `EXPECTED_TS`, 32'h58D8_4C26, expected value at word 1 (1490570278)
- `TIMEOUT_CYCLES`, 1024, maximum cycles per read transaction, range 2..65535
- `ADDR_W`, 1, word-address width of `avm_address`

Ports:
- `clock` in 1: single clock for all logic.
- `reset_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request to run a check. Ignored while busy.
- `avm_address` out ADDR_W: word address. 0 selects the ID, 1 selects the timestamp.
- `avm_read` out 1: read request.
- `avm_waitrequest` in 1: slave stall.
- `avm_readdatavalid` in 1: read data qualifier.
- `avm_readdata` in 32: read data.
- `busy` out 1: check in progress.
- `done` out 1: sticky; result valid.
- `id_ok` out 1: captured ID equals `EXPECTED_ID`.
- `ts_ok` out 1: captured timestamp equals `EXPECTED_TS`.
- `timeout_err` out 1: a transaction exceeded `TIMEOUT_CYCLES`.
- `id_value` out 32: captured ID.
- `ts_value` out 32: captured timestamp.

## Operation
- States: IDLE, REQ_ID, WAIT_ID, REQ_TS, WAIT_TS, CHECK, FINISH.
- IDLE + `start` → REQ_ID. This clears `done`, `id_ok`, `ts_ok`, `timeout_err`, `id_value` and `ts_value`, reloads the timeout counter and sets `busy`.
- REQ_ID drives `avm_read=1`, `avm_address=0`. Address and read stay stable while `avm_waitrequest=1`.
  - Command accepted (`avm_read & !avm_waitrequest`) with `avm_readdatavalid=1` in the same cycle: capture `avm_readdata` into `id_value` and go to REQ_TS.
  - Command accepted without data: go to WAIT_ID. `avm_read` deasserts.
- WAIT_ID: on `avm_readdatavalid`, capture data and go to REQ_TS.
- `avm_readdatavalid` seen outside REQ_*/WAIT_* is ignored.
- REQ_TS and WAIT_TS mirror REQ_ID and WAIT_ID with address 1, capturing into `ts_value`. Completion goes to CHECK.
- CHECK: register `id_ok`, `ts_ok` from 32-bit equality, then go to FINISH.
- FINISH: set `done`, clear `busy`, return to IDLE. Results hold until the next accepted `start`.
- Timeout:
  - The counter reloads to `TIMEOUT_CYCLES-1` on entry to REQ_ID and on entry to REQ_TS.
  - It decrements every cycle in REQ_*/WAIT_*.
  - If the counter reaches 0 with the transaction not complete: `avm_read` drops, `timeout_err=1`, `id_ok=ts_ok=0`, and the FSM goes to FINISH. No retry.
- `start` while `busy` is ignored. No queuing.
- Reset mid-transaction aborts immediately. There is no outstanding-read tracking, because the fabric is reset by the same `reset_n`.

## Timing
- Reset values:
  - `avm_read=0`, `avm_address=0`
  - `busy=0`, `done=0`
  - `id_ok=0`, `ts_ok=0`, `timeout_err=0`
  - `id_value=0`, `ts_value=0`
  - state IDLE
- `avm_read`/`avm_address` are registered. REQ_ID asserts in the cycle after `start` is sampled.
- Zero-wait, zero-latency slave (waitrequest=0, readdatavalid with accept): `start` at cycle 0 gives `avm_read` in cycles 1–2, CHECK at cycle 3, `done=1` from cycle 5.
- Each wait-state or latency cycle adds one cycle to the total.
- At most one read is outstanding. A new command is never issued before the previous `readdatavalid`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Shared package `niosII_system_sysid_pkg` holds:
  - the state enum
  - `SYSID_ID_OFFSET=0`, `SYSID_TS_OFFSET=1`
  - default expected-value constants
- One natural sub-module, `niosII_system_sysid_timeout`: loadable down-counter with an `expired` flag. It is instantiated once and reloaded per transaction.

## Test plan
- **Matching zero-latency slave.** Slave returns 0 / 0x58D84C26; pulse `start`. Required: `done=1`, `id_ok=ts_ok=1`, `timeout_err=0`, `done` at cycle 5.
- **Mismatched timestamp.** Slave returns 0x58D84C27 at word 1. Required: `id_ok=1`, `ts_ok=0`, `ts_value=0x58D84C27`.
- **Backpressure and latency.** `avm_waitrequest` high for 3 cycles, `readdatavalid` 2 cycles after accept. Required: address and read stable during the stall, correct capture, `done` at cycle 5+2×(3+2).
- **Timeout.** `TIMEOUT_CYCLES=8`, slave never deasserts `waitrequest` on word 1. Required: `avm_read` drops after 8 cycles in REQ_TS, `timeout_err=1`, `id_ok=ts_ok=0`, `done=1`, `id_value` retained.
- **`start` while busy, and mid-run reset.** Second `start` while busy produces no extra reads. Asserting `reset_n=0` during WAIT_ID returns all outputs to reset values in the same cycle. A fresh `start` afterwards completes normally.
